// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite command queue: command word layout,
// info codes and the issue FSM state encoding.
package sprite_pkg;

  localparam int unsigned CMD_W         = 32;
  localparam int unsigned COMPONENT_LSB = 26;
  localparam int unsigned CHILD_LSB     = 21;
  localparam int unsigned INFO_LSB      = 17;
  localparam int unsigned TYPE_LSB      = 14;
  localparam int unsigned BUFFER_BIT    = 13;
  localparam int unsigned DATA_LSB      = 0;

  localparam logic [3:0] INFO_NOP    = 4'h0;
  localparam logic [3:0] INFO_UPDATE = 4'h1;
  localparam logic [3:0] INFO_FLUSH  = 4'hF;

  typedef struct packed {
    logic [5:0]  component;
    logic [4:0]  child;
    logic [3:0]  info;
    logic [2:0]  kind;
    logic        buffer;
    logic [12:0] data;
  } sprite_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_VBLANK,
    ST_WAIT_ACTIVE
  } state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO; a push to a full FIFO is taken only when a pop frees a slot
// in the same cycle.
module cmd_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [31:0]            din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [31:0]            head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_cmd_queue.sv
// Avalon-MM command queue that broadcasts sprite commands, holding flush
// commands until vertical blanking so at most one flush lands per frame.
module sprite_cmd_queue
  import sprite_pkg::*;
#(
  parameter int unsigned DEPTH        = 16,
  parameter logic [9:0]  VBLANK_START = 10'd480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write,
  input  logic        read,
  input  logic        chipselect,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          cmd_wr;
  logic          ctl_wr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_head;
  sprite_cmd_t   head_cmd;
  sprite_cmd_t   cmd_d;
  logic          head_flush;
  logic          head_ready;
  logic          in_vblank;
  logic          frame_inc;
  logic          overflow;
  logic [15:0]   frame_count;
  state_t        state;
  state_t        state_d;

  assign cmd_wr     = chipselect & write & ~address;
  assign ctl_wr     = chipselect & write & address;
  assign head_cmd   = sprite_cmd_t'(fifo_head);
  assign head_flush = ~fifo_empty & (head_cmd.info == INFO_FLUSH);
  assign head_ready = ~fifo_empty & (head_cmd.info != INFO_FLUSH);
  assign in_vblank  = (vcount >= VBLANK_START);

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_wr),
    .pop   (fifo_pop),
    .din   (writedata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (fifo_head)
  );

  // IDLE and ISSUE decide identically so consecutive entries issue with no gap.
  always_comb begin
    state_d    = state;
    fifo_pop   = 1'b0;
    frame_inc  = 1'b0;
    cmd_d      = '0;
    cmd_d.info = INFO_NOP;
    case (state)
      ST_IDLE, ST_ISSUE: begin
        if (head_ready) begin
          fifo_pop = 1'b1;
          cmd_d    = head_cmd;
          state_d  = ST_ISSUE;
        end else if (head_flush) begin
          state_d = ST_WAIT_VBLANK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT_VBLANK: begin
        if (in_vblank && head_flush) begin
          fifo_pop  = 1'b1;
          cmd_d     = head_cmd;
          frame_inc = 1'b1;
          state_d   = ST_WAIT_ACTIVE;
        end
      end
      ST_WAIT_ACTIVE: begin
        // Non-flush entries keep flowing; a flush head waits for active video.
        if (head_ready) begin
          fifo_pop = 1'b1;
          cmd_d    = head_cmd;
        end
        if (!in_vblank) state_d = head_ready ? ST_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cmd_out     <= '0;
      frame_count <= '0;
    end else begin
      state   <= state_d;
      cmd_out <= cmd_d;
      if (frame_inc) frame_count <= frame_count + 16'd1;
    end
  end

  // A dropped write in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset)                              overflow <= 1'b0;
    else if (cmd_wr && fifo_full && !fifo_pop) overflow <= 1'b1;
    else if (ctl_wr && writedata[0])        overflow <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (chipselect && read) begin
      if (!address)
        readdata <= {overflow, (state == ST_WAIT_VBLANK), 9'b0, 5'(fifo_count), frame_count};
      else
        readdata <= '0;
    end
  end

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Self-checking bench for sprite_cmd_queue: directed scenarios plus a
// randomized run scored against an ordering/frame-rule reference model.
module tb_sprite_cmd_queue;

  localparam int unsigned DEPTH = 16;
  localparam int          VB    = 480;
  localparam logic [31:0] FLUSH_W = 32'h001E2000;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic        read;
  logic        chipselect;
  logic        address;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;

  int total = 0;
  int bad   = 0;
  int fc_exp = 0;

  always #5 clk = ~clk;

  sprite_cmd_queue #(.DEPTH(DEPTH), .VBLANK_START(10'd480)) dut (
    .clk        (clk),
    .reset      (reset),
    .write      (write),
    .read       (read),
    .chipselect (chipselect),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .vcount     (vcount),
    .cmd_out    (cmd_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  function automatic logic [31:0] status(input bit ovf, input bit fp, input int cnt, input int fc);
    return {ovf, fp, 9'b0, 5'(cnt), 16'(fc)};
  endfunction

  function automatic bit is_flush(input logic [31:0] w);
    return w[20:17] == 4'hF;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 1'b0; writedata = 32'h38020123;
    tick(); tick();
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL reset_cmd: got %h expected %h", cmd_out, 32'h0); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_rd: got %h expected %h", readdata, 32'h0); end
    chipselect = 1'b0; write = 1'b0; reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL reset_write_ignored: got %h expected %h", cmd_out, 32'h0); end
    end
    rd(1'b0, d);
    total++; if (d !== status(0, 0, 0, 0)) begin bad++; $display("FAIL reset_status: got %h expected %h", d, status(0, 0, 0, 0)); end
  endtask

  task automatic test_single();
    logic [31:0] d;
    vcount = 10'd100;
    wr(1'b0, 32'h38020123);
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL single_e0: got %h expected %h", cmd_out, 32'h0); end
    tick();
    total++; if (cmd_out !== 32'h38020123) begin bad++; $display("FAIL single_e1: got %h expected %h", cmd_out, 32'h38020123); end
    tick();
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL single_e2: got %h expected %h", cmd_out, 32'h0); end
    rd(1'b0, d);
    total++; if (d !== status(0, 0, 0, fc_exp)) begin bad++; $display("FAIL single_status: got %h expected %h", d, status(0, 0, 0, fc_exp)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    vcount = 10'd150;
    wr(1'b0, 32'h38020001);
    wr(1'b0, 32'h38020002);
    total++; if (cmd_out !== 32'h38020001) begin bad++; $display("FAIL b2b_0: got %h expected %h", cmd_out, 32'h38020001); end
    wr(1'b0, 32'h38020003);
    total++; if (cmd_out !== 32'h38020002) begin bad++; $display("FAIL b2b_1: got %h expected %h", cmd_out, 32'h38020002); end
    tick();
    total++; if (cmd_out !== 32'h38020003) begin bad++; $display("FAIL b2b_2: got %h expected %h", cmd_out, 32'h38020003); end
    tick();
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL b2b_nop: got %h expected %h", cmd_out, 32'h0); end
    rd(1'b0, d);
    total++; if (d !== status(0, 0, 0, fc_exp)) begin bad++; $display("FAIL b2b_status: got %h expected %h", d, status(0, 0, 0, fc_exp)); end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    vcount = 10'd200;
    wr(1'b0, FLUSH_W);
    wr(1'b0, 32'h38020777);
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL flush_hold: got %h expected %h", cmd_out, 32'h0); end
    end
    vcount = 10'd480;
    tick();
    total++; if (cmd_out !== FLUSH_W) begin bad++; $display("FAIL flush_issue: got %h expected %h", cmd_out, FLUSH_W); end
    fc_exp++;
    tick();
    total++; if (cmd_out !== 32'h38020777) begin bad++; $display("FAIL flush_follow: got %h expected %h", cmd_out, 32'h38020777); end
    tick();
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL flush_nop: got %h expected %h", cmd_out, 32'h0); end
    vcount = 10'd0;
    tick(); tick(); tick();
    rd(1'b0, d);
    total++; if (d !== status(0, 0, 0, fc_exp)) begin bad++; $display("FAIL flush_status: got %h expected %h", d, status(0, 0, 0, fc_exp)); end
  endtask

  task automatic test_two_flush();
    logic [31:0] d;
    int n;
    vcount = 10'd490;
    wr(1'b0, FLUSH_W | 32'h1);
    wr(1'b0, FLUSH_W | 32'h2);
    n = 0;
    do begin tick(); n++; end while (cmd_out === 32'h0 && n < 6);
    total++; if (cmd_out !== (FLUSH_W | 32'h1)) begin bad++; $display("FAIL two_flush_first: got %h expected %h", cmd_out, FLUSH_W | 32'h1); end
    fc_exp++;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL two_flush_same_frame: got %h expected %h", cmd_out, 32'h0); end
    end
    vcount = 10'd10;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL two_flush_active: got %h expected %h", cmd_out, 32'h0); end
    end
    vcount = 10'd480;
    tick();
    total++; if (cmd_out !== (FLUSH_W | 32'h2)) begin bad++; $display("FAIL two_flush_second: got %h expected %h", cmd_out, FLUSH_W | 32'h2); end
    fc_exp++;
    tick();
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL two_flush_nop: got %h expected %h", cmd_out, 32'h0); end
    vcount = 10'd0;
    tick(); tick();
    rd(1'b0, d);
    total++; if (d !== status(0, 0, 0, fc_exp)) begin bad++; $display("FAIL two_flush_status: got %h expected %h", d, status(0, 0, 0, fc_exp)); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    int n;
    vcount = 10'd100;
    wr(1'b0, FLUSH_W);
    for (int i = 1; i <= 16; i++) wr(1'b0, 32'h38020000 | 32'(i));
    rd(1'b0, d);
    total++; if (d !== status(1, 1, 16, fc_exp)) begin bad++; $display("FAIL ovf_status: got %h expected %h", d, status(1, 1, 16, fc_exp)); end
    rd(1'b1, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ctl_read: got %h expected %h", d, 32'h0); end
    wr(1'b1, 32'h1);
    rd(1'b0, d);
    total++; if (d !== status(0, 1, 16, fc_exp)) begin bad++; $display("FAIL ovf_clear: got %h expected %h", d, status(0, 1, 16, fc_exp)); end
    vcount = 10'd480;
    n = 0;
    do begin tick(); n++; end while (cmd_out === 32'h0 && n < 6);
    total++; if (cmd_out !== FLUSH_W) begin bad++; $display("FAIL ovf_flush: got %h expected %h", cmd_out, FLUSH_W); end
    fc_exp++;
    for (int i = 1; i <= 15; i++) begin
      tick();
      total++; if (cmd_out !== (32'h38020000 | 32'(i))) begin bad++; $display("FAIL ovf_drain: got %h expected %h", cmd_out, 32'h38020000 | 32'(i)); end
    end
    tick();
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL ovf_dropped: got %h expected %h", cmd_out, 32'h0); end
    vcount = 10'd0;
    tick(); tick(); tick();
    rd(1'b0, d);
    total++; if (d !== status(0, 0, 0, fc_exp)) begin bad++; $display("FAIL ovf_final: got %h expected %h", d, status(0, 0, 0, fc_exp)); end
  endtask

  task automatic test_reset_vblank();
    logic [31:0] d;
    vcount = 10'd100;
    wr(1'b0, FLUSH_W);
    for (int i = 1; i <= 4; i++) wr(1'b0, 32'h38020100 | 32'(i));
    tick();
    rd(1'b0, d);
    total++; if (d !== status(0, 1, 5, fc_exp)) begin bad++; $display("FAIL rstv_pending: got %h expected %h", d, status(0, 1, 5, fc_exp)); end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    fc_exp = 0;
    total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL rstv_cmd: got %h expected %h", cmd_out, 32'h0); end
    total++; if (readdata !== 32'h0) begin bad++; $display("FAIL rstv_rd: got %h expected %h", readdata, 32'h0); end
    vcount = 10'd480;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL rstv_no_flush: got %h expected %h", cmd_out, 32'h0); end
    end
    rd(1'b0, d);
    total++; if (d !== status(0, 0, 0, 0)) begin bad++; $display("FAIL rstv_status: got %h expected %h", d, status(0, 0, 0, 0)); end
    vcount = 10'd0;
    tick(); tick();
  endtask

  // Model: issued words must follow write order; a flush may appear only on
  // a blanking line and only after an active line since the previous flush.
  task automatic test_random();
    logic [31:0] q[$];
    logic [31:0] w;
    logic [31:0] d;
    bit          do_wr;
    bit          armed;
    int          vc;
    int          vc_edge;
    int          flushes;
    int          cyc;
    armed = 1'b1;
    flushes = 0;
    vc = 0;
    cyc = 0;
    while ((cyc < 600 || q.size() != 0) && cyc < 4000) begin
      do_wr = (cyc < 600) && (q.size() <= DEPTH - 2) && ($urandom_range(2) == 0);
      if (do_wr) begin
        w = $urandom();
        w[20:17] = ($urandom_range(5) == 0) ? 4'hF : 4'($urandom_range(14, 1));
        chipselect = 1'b1; write = 1'b1; address = 1'b0; writedata = w;
      end
      vcount = 10'(vc);
      vc_edge = vc;
      tick();
      chipselect = 1'b0; write = 1'b0;
      if (cmd_out !== 32'h0) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_unexpected: got %h expected %h", cmd_out, 32'h0);
        end else begin
          if (cmd_out !== q[0]) begin bad++; $display("FAIL rand_order: got %h expected %h", cmd_out, q[0]); end
          if (is_flush(q[0])) begin
            total++;
            if (!(vc_edge >= VB && armed)) begin
              bad++; $display("FAIL rand_flush_timing: got vcount=%0d armed=%0d expected vcount>=%0d armed=1", vc_edge, armed, VB);
            end
            armed = 1'b0;
            flushes++;
          end
          void'(q.pop_front());
        end
      end
      if (vc_edge < VB) armed = 1'b1;
      if (do_wr) q.push_back(w);
      vc = (vc + 37) % 525;
      cyc++;
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_drain_timeout: got %0d pending expected 0", q.size()); end
    vcount = 10'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (cmd_out !== 32'h0) begin bad++; $display("FAIL rand_idle: got %h expected %h", cmd_out, 32'h0); end
    end
    fc_exp += flushes;
    rd(1'b0, d);
    total++; if (d !== status(0, 0, 0, fc_exp)) begin bad++; $display("FAIL rand_status: got %h expected %h", d, status(0, 0, 0, fc_exp)); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; write = 1'b0; read = 1'b0; chipselect = 1'b0;
    address = 1'b0; writedata = 32'h0; vcount = 10'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_two_flush();
    test_overflow();
    test_reset_vblank();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_cmd_queue.md
SPRITE_CMD_QUEUE -- requirements
Module: sprite_cmd_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16: command FIFO entries; power of two, at least 4.
REQ-002 SHALL have parameter VBLANK_START, default 10'd480: first vcount line of vertical blanking.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port write, input, 1: Avalon write strobe, qualified by chipselect.
REQ-006 SHALL have port read, input, 1: Avalon read strobe, qualified by chipselect.
REQ-007 SHALL have port chipselect, input, 1: Avalon select.
REQ-008 SHALL have port address, input, 1: 0 = command/status, 1 = control.
REQ-009 SHALL have port writedata, input, 32: CPU command word {component[31:26], child[25:21], info[20:17], type[16:14], buffer[13], data[12:0]}.
REQ-010 SHALL have port readdata, output, 32: status word.
REQ-011 SHALL have port vcount, input, 10: current VGA line.
REQ-012 SHALL have port cmd_out, output, 32: command broadcast to all sprite display blocks; same field layout as writedata.

Function
REQ-013 SHALL treat a cmd_out with info = 4'h0 as NOP and drive cmd_out = 32'h0 whenever no command issues.
REQ-014 SHALL push writedata into the FIFO on chipselect & write & address==0 when not full.
REQ-015 SHALL drop a write to a full FIFO and set sticky overflow; FIFO contents unchanged.
REQ-016 SHALL accept a push on a full FIFO in the same cycle a pop occurs.
REQ-017 SHALL clear overflow on chipselect & write & address==1 with writedata[0]=1; a simultaneous overflow event wins (flag stays set).
REQ-018 SHALL run FSM states IDLE, ISSUE, WAIT_VBLANK, WAIT_ACTIVE.
REQ-019 IDLE: cmd_out=0; FIFO non-empty and head.info != 4'hF -> ISSUE; head.info == 4'hF -> WAIT_VBLANK.
REQ-020 ISSUE: pops head, cmd_out = head for exactly one cycle, returns to IDLE; back-to-back non-flush entries issue on consecutive cycles with no NOP gap between them.
REQ-021 Latency: a word pushed at edge E into an empty FIFO SHALL appear on cmd_out after edge E+1 and return to NOP after edge E+2 (unless followed).
REQ-022 WAIT_VBLANK: cmd_out=0, head held, later entries blocked (order preserved); when vcount >= VBLANK_START, pop flush, drive it on cmd_out one cycle, increment frame_count, -> WAIT_ACTIVE.
REQ-023 WAIT_ACTIVE: cmd_out=0; non-flush entries issue as in IDLE/ISSUE; a flush head waits until vcount < VBLANK_START has been seen, so at most one flush per frame.
REQ-024 frame_count SHALL be 16 bits, wrapping 16'hFFFF -> 0.
REQ-025 readdata SHALL register one cycle after chipselect & read, address 0: {overflow[31], flush_pending[30], 9'b0, count[20:16] zero-extended, frame_count[15:0]}; address 1 reads 0.
REQ-026 count SHALL equal entries held (0..DEPTH), updated the cycle after push/pop.

Reset
REQ-027 On reset: FIFO empty, count=0, overflow=0, frame_count=0, state=IDLE, cmd_out=32'h0, readdata=32'h0; writes in the reset cycle are ignored.
REQ-028 Reset mid-WAIT_VBLANK SHALL discard the pending flush; no flush issues afterward without a new write.

Structure
REQ-029 Package sprite_pkg SHALL hold field bit positions, INFO_NOP=4'h0, INFO_UPDATE=4'h1, INFO_FLUSH=4'hF, and the FSM state enum.
REQ-030 The FIFO SHALL be sub-module cmd_fifo (push, pop, full, empty, count, head); FSM and Avalon logic in sprite_cmd_queue.

Verification
REQ-031 Write 32'h38020123 (info 1) at vcount=100 -> cmd_out=32'h38020123 one cycle after edge E+1, then 32'h0.
REQ-032 Write three info-1 words back-to-back -> three consecutive cmd_out cycles in order, count returns to 0.
REQ-033 Write flush 32'h001E2000 then update at vcount=200 -> cmd_out stays 0 until vcount=480, flush issues one cycle, update issues next cycle, frame_count=1.
REQ-034 Two flushes queued in one blanking -> second issues only at next frame's vcount=480; frame_count=2.
REQ-035 Write 17 words with a flush at head during active video -> 17th dropped, status bit31=1, count=16; control write 1 -> bit31=0.
REQ-036 Assert reset while in WAIT_VBLANK with 5 entries -> count=0, cmd_out=0, no flush at vcount=480.
